// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor stage reused LSB-first over WIDTH cycles.
// Optional registered zero flag on the result when SUB_ZERO_FLAG_EN is defined.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             bf;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             next_bf;
    logic [WIDTH-1:0] next_work;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        d_bit     = a_sh[0] ^ b_sh[0] ^ bf;
        next_bf   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bf);
        next_work = {d_bit, work[WIDTH-1:1]};
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bf    <= b_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work <= next_work;
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    bf   <= next_bf;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Result registers move only here, so they hold through IDLE and RUN.
                        diff   <= next_work;
                        borrow <= next_bf;
`ifdef SUB_ZERO_FLAG_EN
                        zero   <= (next_work == '0);
`endif
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: table vectors, random vectors and multi-cycle corner cases.
// Zero-flag checks compile in when SUB_ZERO_FLAG_EN is defined.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_ZERO_FLAG_EN
    logic             zero;
`endif

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SUB_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             b_in;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_borrow;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
    } result_t;

    result_t          sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] prev_diff = '0;
    logic             prev_borrow = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one operation; optionally pulses a second start with other operands mid-RUN.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vbin, input result_t exp, input int glitch_at);
        int      lat;
        int      busy_cycles;
        result_t got;
        @(negedge clk);
        check("idle_done_low", done, 1'b0);
        a = va; b = vb; b_in = vbin; start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 4 * WIDTH) begin
            if (busy) busy_cycles++;
            if (lat == WIDTH / 2) begin
                check("diff_hold_run", diff, prev_diff);
                check("borrow_hold_run", borrow, prev_borrow);
            end
            if (lat == 2) begin
                a = ~va; b = ~vb; b_in = ~vbin;
            end
            if (glitch_at >= 0 && lat == glitch_at) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, WIDTH);
        check("busy_cycles", busy_cycles, WIDTH);
        check("busy_in_done", busy, 1'b0);
        got = sb.pop_front();
        check("diff", diff, got.diff);
        check("borrow", borrow, got.borrow);
`ifdef SUB_ZERO_FLAG_EN
        check("zero", zero, (got.diff == '0));
`endif
        prev_diff = got.diff;
        prev_borrow = got.borrow;
    endtask

    function automatic result_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                      input logic vbin);
        logic [WIDTH:0] full;
        result_t r;
        full = {1'b0, va} - {1'b0, vb} - {{WIDTH{1'b0}}, vbin};
        r.diff = full[WIDTH-1:0];
        r.borrow = full[WIDTH];
        return r;
    endfunction

    initial begin
        vec_t    vecs[8];
        result_t exp;
        int      pulses;
        int      last;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_borrow", borrow, 1'b0);
`ifdef SUB_ZERO_FLAG_EN
        check("rst_zero", zero, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exp.diff = vecs[i].exp_diff;
            exp.borrow = vecs[i].exp_borrow;
            run_op(vecs[i].a, vecs[i].b, vecs[i].b_in, exp, -1);
        end

        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rbin;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rbin = 1'($urandom_range(1));
            run_op(ra, rb, rbin, model(ra, rb, rbin), -1);
        end

        // Start pulsed 3 cycles into RUN with different operands must be ignored.
        exp.diff = 8'h1E; exp.borrow = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, exp, 3);
        @(negedge clk);
        check("no_second_op", busy, 1'b0);

        // Reset during RUN aborts with no done pulse and clears the result.
        @(negedge clk);
        a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, '0);
        check("abort_borrow", borrow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_diff_after", diff, '0);
        prev_diff = '0;
        prev_borrow = 1'b0;
        exp.diff = 8'h22; exp.borrow = 1'b0;
        run_op(8'h33, 8'h11, 1'b0, exp, -1);

        // Start held high: one result every WIDTH+1 cycles.
        @(negedge clk);
        a = 8'h80; b = 8'h01; b_in = 1'b0; start = 1'b1;
        pulses = 0;
        last = -1;
        for (int cyc = 0; cyc < 6 * (WIDTH + 1) && pulses < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("b2b_diff", diff, 8'h7F);
                check("b2b_borrow", borrow, 1'b0);
                if (last >= 0) check("b2b_interval", cyc - last, WIDTH + 1);
                else check("b2b_first_latency", cyc, WIDTH);
                last = cyc;
            end else if (pulses > 0 && cyc == last + WIDTH / 2) begin
                check("b2b_diff_hold", diff, 8'h7F);
                check("b2b_busy", busy, 1'b1);
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 3);
        @(negedge clk);
        check("b2b_done_one_cycle", done, 1'b0);
        @(negedge clk);
        check("b2b_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller that time-multiplexes a single one-bit full-subtractor stage across a WIDTH-bit operand pair. It computes a − b − b_in LSB-first, one bit per clock, and holds the borrow between cycles. It sits between a requester with a start/done handshake and the one-bit subtract datapath, and trades area for WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  minuend; sampled on the accepted start edge.
- b  input  WIDTH  subtrahend; sampled on the accepted start edge.
- b_in  input  1  initial borrow-in; sampled on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result updates.
- diff  output  WIDTH  result register (a − b − b_in) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b + b_in (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1:
  - latch a, b and b_in into shift registers and the borrow flop;
  - clear bit counter to 0;
  - go to RUN.
- IDLE or DONE, start=0: DONE → IDLE; IDLE stays IDLE.
- RUN, each cycle:
  - bit stage computes d = a_sh[0] ^ b_sh[0] ^ bf;
  - next borrow is (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bf);
  - d shifts into the MSB of the work register; a_sh and b_sh shift right; bf takes the next borrow; counter increments.
- RUN with counter == WIDTH−1: process the final bit, then:
  - copy the work register to diff and the next borrow to borrow;
  - go to DONE.
- DONE lasts one cycle. done=1 and busy=0 during DONE.
- start while in RUN is ignored, with no queueing. Operands that change during RUN have no effect.
- diff and borrow change only on the RUN→DONE edge. They hold the previous result through IDLE and RUN.
- Counter width is clog2(WIDTH). No wrap-around occurs: the counter is cleared on every accepted start.

## Timing
- Reset (rst_n=0, asynchronous), all outputs and registers clear:
  - busy=0, done=0, diff=0, borrow=0;
  - state=IDLE, counter=0.
- Reset mid-RUN aborts the operation and produces no done pulse. diff and borrow read 0 after reset.
- Start accepted at rising edge k:
  - busy=1 from after edge k;
  - bits 0..WIDTH−1 are processed at edges k+1..k+WIDTH;
  - diff, borrow and done are valid after edge k+WIDTH; done drops after edge k+WIDTH+1.
- Latency is start-edge to done = WIDTH cycles. Busy is high for exactly WIDTH cycles.
- Back-to-back operation: start held high during DONE is accepted at that edge. Sustained throughput is one result per WIDTH+1 cycles.
- A start pulse coinciding with reset deassertion is accepted only on an edge where rst_n=1.

## Configuration
- SUB_ZERO_FLAG_EN defined:
  - adds output port zero (1 bit), registered and updated on the same edge as diff;
  - zero=1 iff the new diff == 0, otherwise 0;
  - zero reset value is 0.
- SUB_ZERO_FLAG_EN undefined: the zero port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, b_in=0 → after 8 busy cycles: done pulse, diff=0x1E, borrow=0.
- a=0x10, b=0x20, b_in=0 → diff=0xF0, borrow=1. Then a=0x00, b=0x00, b_in=1 → diff=0xFF, borrow=1.
- With SUB_ZERO_FLAG_EN: a=0xFF, b=0xFF, b_in=0 → diff=0x00, borrow=0, zero=1. Next, a=0x01, b=0x00, b_in=0 → zero=0.
- Start pulsed again 3 cycles into RUN with different operands → ignored; the first result is delivered on schedule; busy stays high for exactly 8 cycles.
- rst_n low for 1 cycle at RUN cycle 4 → busy=0, done never pulses, diff=0, borrow=0. A fresh start then completes normally.
- Start held high continuously with a=0x80, b=0x01 → results 0x7F every 9 cycles; done pulses one cycle each; diff is unchanged between pulses.
